alarm_clock_multi: RTL and testbench

- Parametrised successor to the single-alarm clock.
- Keeps a time-of-day counter (hr/min/sec) advanced by an internal clock-per-second prescaler, with synchronous time load.
- NUM_ALM independent programmable alarm channels, each with its own ringing state machine, acknowledge and auto-timeout.
- Sits between the board clock and the display/buzzer logic.

---
 rtl/alarm_clock_multi.sv | 229 ++++++++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi.sv
// Time-of-day clock (hr/min/sec) with NUM_ALM independent alarm channels, each with ack and
// auto-timeout. Defining ALARM_SNOOZE_EN adds a per-channel snooze input and SNOOZED state.
module alarm_clock_multi #(
  parameter int unsigned CLK_PER_SEC = 1,
  parameter int unsigned NUM_ALM     = 4,
  parameter int unsigned HOURS       = 24,
`ifdef ALARM_SNOOZE_EN
  parameter int unsigned SNOOZE_SEC  = 300,
`endif
  parameter int unsigned RING_SEC    = 60
) (
  input  logic                                           clk,
  input  logic                                           clr,
  input  logic                                           set_time,
  input  logic [7:0]                                     set_hr,
  input  logic [7:0]                                     set_min,
  input  logic [7:0]                                     set_sec,
  input  logic                                           alm_wr,
  input  logic [((NUM_ALM > 1) ? $clog2(NUM_ALM) : 1)-1:0] alm_idx,
  input  logic [7:0]                                     alm_hr,
  input  logic [7:0]                                     alm_min,
  input  logic [7:0]                                     alm_sec,
  input  logic                                           alm_en,
  input  logic [NUM_ALM-1:0]                             ack,
`ifdef ALARM_SNOOZE_EN
  input  logic [NUM_ALM-1:0]                             snooze,
`endif
  output logic [7:0]                                     hr,
  output logic [7:0]                                     min,
  output logic [7:0]                                     sec,
  output logic                                           sec_tick,
  output logic [NUM_ALM-1:0]                             alarm,
  output logic                                           alarm_any
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned RW = $clog2(RING_SEC + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_PER_SEC - 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_SEC);
  localparam logic [7:0]    HR_MAX   = 8'(HOURS - 1);

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = $clog2(SNOOZE_SEC + 1);
  localparam logic [SW-1:0] SNZ_MAX = SW'(SNOOZE_SEC);
  typedef enum logic [1:0] {StIdle, StRing, StSnooze} ch_state_e;
`else
  typedef enum logic [0:0] {StIdle, StRing} ch_state_e;
`endif

  // ---------------------------------------------------------------------------------------------
  // Time of day
  // ---------------------------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic          tick_q;
  logic          tick, load_ok, adv;

  assign tick    = (presc_q == PRE_MAX);
  assign load_ok = set_time && (set_hr <= HR_MAX) && (set_min <= 8'd59) && (set_sec <= 8'd59);
  // A valid load swallows a coincident tick.
  assign adv     = tick && !load_ok;

  always_comb begin
    presc_d = presc_q + PW'(1);
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (load_ok) begin
      presc_d = '0;
      hr_d    = set_hr;
      min_d   = set_min;
      sec_d   = set_sec;
    end else if (tick) begin
      presc_d = '0;
      if (sec_q == 8'd59) begin
        sec_d = '0;
        if (min_q == 8'd59) begin
          min_d = '0;
          hr_d  = (hr_q == HR_MAX) ? '0 : hr_q + 8'd1;
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q <= '0;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= adv;
    end
  end

  assign hr       = hr_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign sec_tick = tick_q;

  // ---------------------------------------------------------------------------------------------
  // Alarm channels
  // ---------------------------------------------------------------------------------------------
  logic [7:0]    ahr_q  [NUM_ALM];
  logic [7:0]    amin_q [NUM_ALM];
  logic [7:0]    asec_q [NUM_ALM];
  logic [NUM_ALM-1:0] en_q;
  ch_state_e     st_q   [NUM_ALM];
  ch_state_e     st_d   [NUM_ALM];
  logic [RW-1:0] ring_q [NUM_ALM];
  logic [RW-1:0] ring_d [NUM_ALM];
`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snz_q  [NUM_ALM];
  logic [SW-1:0] snz_d  [NUM_ALM];
`endif
  logic [NUM_ALM-1:0] wr_hit, match;
  logic               wr_ok;

  assign wr_ok = alm_wr && (32'(alm_idx) < NUM_ALM) && (alm_hr <= HR_MAX) &&
                 (alm_min <= 8'd59) && (alm_sec <= 8'd59);

  // Matches compare against the post-tick time, so loads via set_time never ring.
  for (genvar g = 0; g < NUM_ALM; g++) begin : g_hit
    assign wr_hit[g] = wr_ok && (32'(alm_idx) == 32'(g));
    assign match[g]  = adv && en_q[g] && (ahr_q[g] == hr_d) && (amin_q[g] == min_d) &&
                       (asec_q[g] == sec_d);
  end

  always_comb begin
    for (int i = 0; i < NUM_ALM; i++) begin
      st_d[i]   = st_q[i];
      ring_d[i] = ring_q[i];
`ifdef ALARM_SNOOZE_EN
      snz_d[i]  = snz_q[i];
`endif
      case (st_q[i])
        StIdle: begin
          if (match[i]) begin
            st_d[i]   = StRing;
            ring_d[i] = '0;
          end
        end
        StRing: begin
          if (match[i]) begin
            ring_d[i] = '0;
          end else if (ack[i]) begin
            st_d[i] = StIdle;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze[i]) begin
            st_d[i]  = StSnooze;
            snz_d[i] = '0;
`endif
          end else if (adv) begin
            if ((ring_q[i] + RW'(1)) == RING_MAX) st_d[i] = StIdle;
            else                                   ring_d[i] = ring_q[i] + RW'(1);
          end
        end
`ifdef ALARM_SNOOZE_EN
        StSnooze: begin
          if (match[i]) begin
            st_d[i]   = StRing;
            ring_d[i] = '0;
          end else if (ack[i]) begin
            st_d[i] = StIdle;
          end else if (adv) begin
            if ((snz_q[i] + SW'(1)) == SNZ_MAX) begin
              st_d[i]   = StRing;
              ring_d[i] = '0;
            end else begin
              snz_d[i] = snz_q[i] + SW'(1);
            end
          end
        end
`endif
        default: st_d[i] = StIdle;
      endcase
      // Reprogramming a channel always silences it.
      if (wr_hit[i]) st_d[i] = StIdle;
      if (st_d[i] == StIdle) ring_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      en_q <= '0;
      for (int i = 0; i < NUM_ALM; i++) begin
        ahr_q[i]  <= '0;
        amin_q[i] <= '0;
        asec_q[i] <= '0;
        st_q[i]   <= StIdle;
        ring_q[i] <= '0;
`ifdef ALARM_SNOOZE_EN
        snz_q[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_ALM; i++) begin
        st_q[i]   <= st_d[i];
        ring_q[i] <= ring_d[i];
`ifdef ALARM_SNOOZE_EN
        snz_q[i]  <= snz_d[i];
`endif
        if (wr_hit[i]) begin
          ahr_q[i]  <= alm_hr;
          amin_q[i] <= alm_min;
          asec_q[i] <= alm_sec;
          en_q[i]   <= alm_en;
        end
      end
    end
  end

  always_comb begin
    alarm = '0;
    for (int i = 0; i < NUM_ALM; i++) alarm[i] = (st_q[i] == StRing);
  end

  assign alarm_any = |alarm;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi; a seconds-of-day reference model is compared every cycle
// and literal expectations pin the key scenarios.
`timescale 1ns/1ps
module tb_alarm_clock_multi;
  localparam int CPS  = 4;
  localparam int NA   = 4;
  localparam int HRS  = 24;
  localparam int RING = 3;
  localparam int SNZ  = 2;
  localparam int DAY  = HRS * 3600;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          set_time = 1'b0;
  logic [7:0]    set_hr = '0, set_min = '0, set_sec = '0;
  logic          alm_wr = 1'b0;
  logic [1:0]    alm_idx = '0;
  logic [7:0]    alm_hr = '0, alm_min = '0, alm_sec = '0;
  logic          alm_en = 1'b0;
  logic [NA-1:0] ack = '0;
`ifdef ALARM_SNOOZE_EN
  logic [NA-1:0] snooze = '0;
`endif
  logic [7:0]    hr, min, sec;
  logic          sec_tick;
  logic [NA-1:0] alarm;
  logic          alarm_any;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alarm_clock_multi #(
    .CLK_PER_SEC(CPS),
    .NUM_ALM    (NA),
    .HOURS      (HRS),
`ifdef ALARM_SNOOZE_EN
    .SNOOZE_SEC (SNZ),
`endif
    .RING_SEC   (RING)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .set_time (set_time),
    .set_hr   (set_hr),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .alm_wr   (alm_wr),
    .alm_idx  (alm_idx),
    .alm_hr   (alm_hr),
    .alm_min  (alm_min),
    .alm_sec  (alm_sec),
    .alm_en   (alm_en),
    .ack      (ack),
`ifdef ALARM_SNOOZE_EN
    .snooze   (snooze),
`endif
    .hr       (hr),
    .min      (min),
    .sec      (sec),
    .sec_tick (sec_tick),
    .alarm    (alarm),
    .alarm_any(alarm_any)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds since midnight, channels as ringing/snoozed flags.
  int m_t, m_cyc;
  bit m_tick;
  int a_t   [NA];
  bit a_en  [NA];
  bit m_ring[NA];
  bit m_snz [NA];
  int m_el  [NA];
  int m_sc  [NA];

  always @(posedge clk) begin
    bit load, tk, wok, hit, snz_req;
    if (clr) begin
      m_t = 0; m_cyc = 0; m_tick = 0;
      for (int i = 0; i < NA; i++) begin
        a_t[i] = 0; a_en[i] = 0; m_ring[i] = 0; m_snz[i] = 0; m_el[i] = 0; m_sc[i] = 0;
      end
    end else begin
      load = set_time && int'(set_hr) < HRS && int'(set_min) < 60 && int'(set_sec) < 60;
      tk = 0;
      if (load) begin
        m_t   = int'(set_hr) * 3600 + int'(set_min) * 60 + int'(set_sec);
        m_cyc = 0;
      end else begin
        m_cyc++;
        if (m_cyc == CPS) begin
          m_cyc = 0;
          tk    = 1;
          m_t   = (m_t + 1) % DAY;
        end
      end
      m_tick = tk;
      wok = alm_wr && int'(alm_idx) < NA && int'(alm_hr) < HRS && int'(alm_min) < 60 &&
            int'(alm_sec) < 60;
      for (int i = 0; i < NA; i++) begin
        hit = tk && a_en[i] && (a_t[i] == m_t);
        snz_req = 0;
`ifdef ALARM_SNOOZE_EN
        snz_req = snooze[i];
`endif
        if (hit) begin
          m_ring[i] = 1; m_snz[i] = 0; m_el[i] = 0;
        end else if (m_snz[i]) begin
          if (ack[i]) m_snz[i] = 0;
          else if (tk) begin
            m_sc[i]++;
            if (m_sc[i] >= SNZ) begin m_snz[i] = 0; m_ring[i] = 1; m_el[i] = 0; end
          end
        end else if (m_ring[i]) begin
          if (ack[i]) m_ring[i] = 0;
          else if (snz_req) begin m_ring[i] = 0; m_snz[i] = 1; m_sc[i] = 0; end
          else if (tk) begin
            m_el[i]++;
            if (m_el[i] >= RING) m_ring[i] = 0;
          end
        end
        if (wok && int'(alm_idx) == i) begin
          a_t[i]  = int'(alm_hr) * 3600 + int'(alm_min) * 60 + int'(alm_sec);
          a_en[i] = alm_en;
          m_ring[i] = 0; m_snz[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NA-1:0] ea;
    logic [23:0]   et;
    if (!clr) begin
      for (int i = 0; i < NA; i++) ea[i] = m_ring[i];
      et = {8'(m_t / 3600), 8'((m_t / 60) % 60), 8'(m_t % 60)};
      check("m_time", {8'h0, hr, min, sec}, {8'h0, et});
      check("m_sec_tick", 32'(sec_tick), 32'(m_tick));
      check("m_alarm", 32'(alarm), 32'(ea));
      check("m_alarm_any", 32'(alarm_any), 32'(ea != '0));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_time(input int h, input int m, input int s);
    set_time = 1'b1; set_hr = 8'(h); set_min = 8'(m); set_sec = 8'(s);
    step();
    set_time = 1'b0;
  endtask

  task automatic write_alm(input int idx, input int h, input int m, input int s, input bit en);
    alm_wr = 1'b1; alm_idx = 2'(idx); alm_hr = 8'(h); alm_min = 8'(m); alm_sec = 8'(s);
    alm_en = en;
    step();
    alm_wr = 1'b0;
  endtask

  task automatic pulse_ack(input logic [NA-1:0] v);
    ack = v;
    step();
    ack = '0;
  endtask

  task automatic wait_sec(input int s);
    for (int k = 0; k < 64 && sec != 8'(s); k++) step();
    check("reach_sec", 32'(sec), 32'(s));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nt, first, second;
    repeat (3) step();
    check("rst_time", {8'h0, hr, min, sec}, 32'h0);
    check("rst_alarm", {alarm_any, alarm}, 32'h0);
    check("rst_tick", 32'(sec_tick), 32'h0);
    clr = 1'b0;

    // Prescaler: 8 cycles at 4 cycles/second.
    nt = 0; first = -1; second = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (sec_tick) begin
        nt++;
        if (first < 0) first = c;
        else second = c;
      end
    end
    check("pre_sec", 32'(sec), 32'd2);
    check("pre_ticks", nt, 2);
    check("pre_first", first, 4);
    check("pre_gap", second - first, 4);

    // Rollover 23:59:58 -> 23:59:59 -> 00:00:00.
    load_time(23, 59, 58);
    repeat (4) step();
    check("roll_59", {hr, min, sec}, {8'd23, 8'd59, 8'd59});
    repeat (4) step();
    check("roll_0", {hr, min, sec}, 24'h0);

    // Out-of-range load is ignored.
    load_time(1, 0, 0);
    load_time(10, 60, 0);
    check("bad_load", {hr, min, sec}, {8'd1, 8'd0, 8'd0});

    // Channel programming, including an out-of-range write.
    write_alm(3, 0, 0, 75, 1'b1);
    write_alm(0, 0, 0, 5, 1'b1);
    write_alm(2, 0, 0, 5, 1'b1);
    write_alm(1, 0, 0, 5, 1'b0);
    load_time(0, 0, 0);
    wait_sec(5);
    check("ring_multi", 32'(alarm), 32'b0101);
    check("any_multi", 32'(alarm_any), 32'd1);
    pulse_ack(4'b0011);
    check("ack0", 32'(alarm), 32'b0100);
    check("any_ack", 32'(alarm_any), 32'd1);
    wait_sec(7);
    check("ring_7", 32'(alarm), 32'b0100);
    wait_sec(8);
    check("timeout_8", 32'(alarm), 32'b0000);

    // Loading a matching time does not ring.
    load_time(0, 0, 5);
    check("load_nomatch", 32'(alarm), 32'b0000);
    wait_sec(6);
    check("no_ring_6", 32'(alarm), 32'b0000);

    // Write to a ringing channel silences it.
    load_time(0, 0, 4);
    wait_sec(5);
    check("ring_again", 32'(alarm), 32'b0101);
    write_alm(2, 0, 0, 5, 1'b0);
    check("wr_idle", 32'(alarm), 32'b0001);
`ifdef ALARM_SNOOZE_EN
    snooze = 4'b0001;
    step();
    snooze = '0;
    check("snoozed", 32'(alarm), 32'b0000);
    wait_sec(6);
    check("snz_6", 32'(alarm), 32'b0000);
    wait_sec(7);
    check("rering_7", 32'(alarm), 32'b0001);
    snooze = 4'b0001;
    step();
    snooze = '0;
    check("snoozed2", 32'(alarm), 32'b0000);
    pulse_ack(4'b0001);
    check("ack_snz", 32'(alarm), 32'b0000);
    wait_sec(10);
    check("snz_idle_10", 32'(alarm), 32'b0000);
`else
    wait_sec(7);
    check("still_ring_7", 32'(alarm), 32'b0001);
    wait_sec(8);
    check("timeout_again", 32'(alarm), 32'b0000);
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
